// File: rtl/hazard_sched.sv
// Hazard scheduler: stall/flush/hold controls, E-stage forwarding, mul/div occupancy FSM with watchdog, post-reset fill guard; HAZARD_PERF_EN adds perf counters.
// Latency: all controls combinational from registered state and current inputs (0 cycles).
// Backpressure: Busy holds ID/EX onward, StallF/StallD hold PC and IF/ID while a multicycle op runs or on load-use.
module hazard_sched #(
  parameter int RESET_HOLD = 2,
  parameter int MC_TIMEOUT = 64,
  parameter int CNT_W      = 32
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [4:0]       rs1D,
  input  logic [4:0]       rs2D,
  input  logic [4:0]       rs1E,
  input  logic [4:0]       rs2E,
  input  logic [4:0]       rdE,
  input  logic [4:0]       rdM,
  input  logic [4:0]       rdW,
  input  logic             RegWriteE,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             MemtoRegE,
  input  logic             MispredE,
  input  logic             MCycleStartE,
  input  logic             MCycleDone,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             FlushE,
  output logic             Busy,
  output logic             MCycleGo,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             McTimeout,
  output logic [CNT_W-1:0] PerfStall,
  output logic [CNT_W-1:0] PerfFlush,
  output logic [CNT_W-1:0] PerfBusy
);

  localparam int HOLD_W = (RESET_HOLD > 0) ? $clog2(RESET_HOLD + 1) : 1;
  localparam int WD_W   = (MC_TIMEOUT > 1) ? $clog2(MC_TIMEOUT) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT = HOLD_W'(RESET_HOLD);
  localparam logic [WD_W-1:0]   WD_LAST   = WD_W'(MC_TIMEOUT - 1);

  typedef enum logic {IDLE, MC_RUN} state_t;

  state_t            state, state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [WD_W-1:0]   wd_cnt, wd_nxt;
  logic              holding;
  logic              busy;
  logic              go;
  logic              timeout_set;
  logic              load_use;

  assign holding  = (hold_cnt != '0);
  assign load_use = MemtoRegE && RegWriteE && (rdE != 5'd0) &&
                    ((rdE == rs1D) || (rdE == rs2D));

  // Occupancy FSM; frozen during reset and the fill guard.
  always_comb begin
    state_nxt   = state;
    wd_nxt      = wd_cnt;
    busy        = 1'b0;
    go          = 1'b0;
    timeout_set = 1'b0;
    if (!RESET && !holding) begin
      case (state)
        IDLE: begin
          if (MCycleStartE && !MispredE) begin
            go        = 1'b1;
            busy      = 1'b1;
            state_nxt = MC_RUN;
            wd_nxt    = '0;
          end
        end
        MC_RUN: begin
          if (MCycleDone) begin
            state_nxt = IDLE;
          end else if (wd_cnt == WD_LAST) begin
            timeout_set = 1'b1;
            state_nxt   = IDLE;
          end else begin
            busy   = 1'b1;
            wd_nxt = wd_cnt + WD_W'(1);
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    FlushE   = 1'b0;
    Busy     = busy;
    MCycleGo = go;
    if (RESET || holding) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (busy) begin
      StallF = 1'b1;
      StallD = 1'b1;
    end else if (MispredE) begin
      FlushD = 1'b1;
      FlushE = 1'b1;
    end else if (load_use) begin
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
    end
  end

  // M-stage result is newer than W, so it wins; x0 is hardwired zero.
  always_comb begin
    ForwardAE = 2'b00;
    ForwardBE = 2'b00;
    if (RegWriteM && (rdM != 5'd0) && (rdM == rs1E))      ForwardAE = 2'b10;
    else if (RegWriteW && (rdW != 5'd0) && (rdW == rs1E)) ForwardAE = 2'b01;
    if (RegWriteM && (rdM != 5'd0) && (rdM == rs2E))      ForwardBE = 2'b10;
    else if (RegWriteW && (rdW != 5'd0) && (rdW == rs2E)) ForwardBE = 2'b01;
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state     <= IDLE;
      hold_cnt  <= HOLD_INIT;
      wd_cnt    <= '0;
      McTimeout <= 1'b0;
    end else begin
      state  <= state_nxt;
      wd_cnt <= wd_nxt;
      if (holding)     hold_cnt  <= hold_cnt - HOLD_W'(1);
      if (timeout_set) McTimeout <= 1'b1;
    end
  end

`ifdef HAZARD_PERF_EN
  logic             stall_evt;
  logic             flush_evt;
  logic [CNT_W-1:0] perf_stall_q, perf_flush_q, perf_busy_q;

  assign stall_evt = !RESET && !holding && !busy && !MispredE && load_use;
  assign flush_evt = !RESET && !holding && !busy && MispredE;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
      perf_busy_q  <= '0;
    end else begin
      if (stall_evt && (perf_stall_q != '1)) perf_stall_q <= perf_stall_q + CNT_W'(1);
      if (flush_evt && (perf_flush_q != '1)) perf_flush_q <= perf_flush_q + CNT_W'(1);
      if (busy && (perf_busy_q != '1))       perf_busy_q  <= perf_busy_q + CNT_W'(1);
    end
  end

  assign PerfStall = perf_stall_q;
  assign PerfFlush = perf_flush_q;
  assign PerfBusy  = perf_busy_q;
`else
  assign PerfStall = '0;
  assign PerfFlush = '0;
  assign PerfBusy  = '0;
`endif

endmodule

// File: tb/tb_hazard_sched.sv
// Randomized + directed bench for hazard_sched against a cycle-stamped behavioural model.
module tb_hazard_sched;
  localparam int HOLD  = 2;
  localparam int MC_TO = 8;
  localparam int CW    = 32;

  logic          CLK = 1'b0;
  logic          RESET;
  logic [4:0]    rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW;
  logic          RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MispredE;
  logic          MCycleStartE, MCycleDone;
  logic          StallF, StallD, FlushD, FlushE, Busy, MCycleGo, McTimeout;
  logic [1:0]    ForwardAE, ForwardBE;
  logic [CW-1:0] PerfStall, PerfFlush, PerfBusy;

  hazard_sched #(.RESET_HOLD(HOLD), .MC_TIMEOUT(MC_TO), .CNT_W(CW)) dut (
    .CLK(CLK), .RESET(RESET),
    .rs1D(rs1D), .rs2D(rs2D), .rs1E(rs1E), .rs2E(rs2E),
    .rdE(rdE), .rdM(rdM), .rdW(rdW),
    .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
    .MemtoRegE(MemtoRegE), .MispredE(MispredE),
    .MCycleStartE(MCycleStartE), .MCycleDone(MCycleDone),
    .StallF(StallF), .StallD(StallD), .FlushD(FlushD), .FlushE(FlushE),
    .Busy(Busy), .MCycleGo(MCycleGo),
    .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
    .McTimeout(McTimeout),
    .PerfStall(PerfStall), .PerfFlush(PerfFlush), .PerfBusy(PerfBusy)
  );

  always #5 CLK = ~CLK;

  int n_chk = 0;
  int n_bad = 0;

  // Reference model state: fill cycles left, op in flight with its launch cycle stamp.
  int m_cyc = 0;
  int m_hold = HOLD;
  bit m_inflight = 1'b0;
  int m_launch = 0;
  bit m_to = 1'b0;
  int m_ps = 0, m_pf = 0, m_pb = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h exp=%h", tag, m_cyc, got, exp);
    end
  endtask

  function automatic logic [1:0] fwd(input logic [4:0] rs);
    if (RegWriteM && rdM != 0 && rdM == rs) return 2'b10;
    if (RegWriteW && rdW != 0 && rdW == rs) return 2'b01;
    return 2'b00;
  endfunction

  // Called at posedge+1 with inputs set; checks at the falling edge, then advances to next posedge+1.
  task automatic run_cycle();
    logic [5:0] e_ctl;
    bit lu, launch, tmo, fin, ebusy, ev_s, ev_f;
    e_ctl = 6'b0; launch = 0; tmo = 0; fin = 0; ebusy = 0; ev_s = 0; ev_f = 0;
    lu = MemtoRegE && RegWriteE && rdE != 0 && (rdE == rs1D || rdE == rs2D);
    if (RESET || m_hold > 0) begin
      e_ctl = 6'b001100;
    end else begin
      launch = !m_inflight && MCycleStartE && !MispredE;
      tmo    = m_inflight && !MCycleDone && (m_cyc - m_launch == MC_TO);
      fin    = m_inflight && (MCycleDone || tmo);
      ebusy  = launch || (m_inflight && !fin);
      if (ebusy)         e_ctl = {4'b1100, 1'b1, launch};
      else if (MispredE) begin e_ctl = 6'b001100; ev_f = 1; end
      else if (lu)       begin e_ctl = 6'b110100; ev_s = 1; end
    end
    #4;
    chk("ctl{SF,SD,FD,FE,Busy,Go}", {26'b0, StallF, StallD, FlushD, FlushE, Busy, MCycleGo}, {26'b0, e_ctl});
    chk("ForwardAE", {30'b0, ForwardAE}, {30'b0, fwd(rs1E)});
    chk("ForwardBE", {30'b0, ForwardBE}, {30'b0, fwd(rs2E)});
    chk("McTimeout", {31'b0, McTimeout}, {31'b0, m_to});
`ifdef HAZARD_PERF_EN
    chk("PerfStall", PerfStall, m_ps);
    chk("PerfFlush", PerfFlush, m_pf);
    chk("PerfBusy",  PerfBusy,  m_pb);
`else
    chk("PerfStall", PerfStall, 0);
    chk("PerfFlush", PerfFlush, 0);
    chk("PerfBusy",  PerfBusy,  0);
`endif
    if (RESET) begin
      m_hold = HOLD; m_inflight = 0; m_to = 0; m_ps = 0; m_pf = 0; m_pb = 0;
    end else if (m_hold > 0) begin
      m_hold--;
    end else begin
      if (launch) begin m_inflight = 1; m_launch = m_cyc; end
      else if (fin) begin m_inflight = 0; if (tmo) m_to = 1; end
      if (ev_s)  m_ps++;
      if (ev_f)  m_pf++;
      if (ebusy) m_pb++;
    end
    m_cyc++;
    @(posedge CLK); #1;
  endtask

  task automatic clr();
    {rs1D, rs2D, rs1E, rs2E, rdE, rdM, rdW} = '0;
    {RegWriteE, RegWriteM, RegWriteW, MemtoRegE, MispredE, MCycleStartE, MCycleDone} = '0;
  endtask

  initial begin
    RESET = 1'b1;
    clr();
    @(posedge CLK); #1;
    // reset and fill guard
    repeat (3) run_cycle();
    RESET = 1'b0;
    repeat (3) run_cycle();
    // load-use, then rdE=x0
    MemtoRegE = 1; RegWriteE = 1; rdE = 5; rs1D = 5;
    run_cycle();
    rdE = 0;
    run_cycle();
    clr();
    // multicycle op done on 4th run cycle
    MCycleStartE = 1; run_cycle();
    MCycleStartE = 0; repeat (3) run_cycle();
    MCycleDone = 1; run_cycle();
    MCycleDone = 0; run_cycle();
    // watchdog expiry, then a stray Done in IDLE
    MCycleStartE = 1; run_cycle();
    MCycleStartE = 0; repeat (10) run_cycle();
    MCycleDone = 1; run_cycle();
    clr();
    // mispredict beats load-use; mispredict under Busy
    MispredE = 1; MemtoRegE = 1; RegWriteE = 1; rdE = 5; rs1D = 5;
    run_cycle();
    clr();
    MCycleStartE = 1; run_cycle();
    MCycleStartE = 0; MispredE = 1; run_cycle();
    MispredE = 0; MCycleDone = 1; run_cycle();
    clr();
    // forwarding priority and x0
    rdM = 7; rdW = 7; RegWriteM = 1; RegWriteW = 1; rs1E = 7; rs2E = 7;
    run_cycle();
    RegWriteM = 0; run_cycle();
    rdW = 0; run_cycle();
    clr();
    // random traffic
    for (int i = 0; i < 3000; i++) begin
      RESET        = ($urandom_range(0, 299) == 0);
      rs1D         = 5'($urandom_range(0, 3));
      rs2D         = 5'($urandom_range(0, 3));
      rs1E         = 5'($urandom_range(0, 3));
      rs2E         = 5'($urandom_range(0, 3));
      rdE          = 5'($urandom_range(0, 3));
      rdM          = 5'($urandom_range(0, 3));
      rdW          = 5'($urandom_range(0, 3));
      RegWriteE    = ($urandom_range(0, 3) != 0);
      RegWriteM    = $urandom_range(0, 1) != 0;
      RegWriteW    = $urandom_range(0, 1) != 0;
      MemtoRegE    = $urandom_range(0, 1) != 0;
      MispredE     = ($urandom_range(0, 7) == 0);
      MCycleStartE = ($urandom_range(0, 3) == 0);
      MCycleDone   = ($urandom_range(0, 7) == 0);
      run_cycle();
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule
